// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect requests, imem word in; PC and IF/ID register out.
// No latency of its own; carries signals only.
// No backpressure here; stall is an input of the bundle.
//
// Signals:
//    stall, branch_taken, branch_target  : requests from the hazard unit / execute stage
//    instruction                         : combinational word from instruction memory for PC_out
//    PC_out                              : instruction memory byte address
//    if_id_pc, if_id_instr, if_id_valid  : IF/ID pipeline register contents
//    fetch_fault                         : sticky misaligned-redirect fault
//    fetch_count                         : saturating count of valid captures
// Modports: master drives the requests and memory word, slave is the fetch stage.
interface fetch_stage_if #(
   parameter int CNT_W = 32
);
   logic             stall;
   logic             branch_taken;
   logic [31:0]      branch_target;
   logic [31:0]      instruction;
   logic [31:0]      PC_out;
   logic [31:0]      if_id_pc;
   logic [31:0]      if_id_instr;
   logic             if_id_valid;
   logic             fetch_fault;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      output stall, branch_taken, branch_target, instruction,
      input  PC_out, if_id_pc, if_id_instr, if_id_valid, fetch_fault, fetch_count
   );

   modport slave (
      input  stall, branch_taken, branch_target, instruction,
      output PC_out, if_id_pc, if_id_instr, if_id_valid, fetch_fault, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures the imem word into IF/ID, handles redirect and fault halt.
// Latency: word at PC_out appears on if_id_instr one edge later; all outputs registered.
// Backpressure: stall holds PC and IF/ID; a redirect overrides stall; HALT ignores both until reset.
//
// Ports:
//    clk   : rising-edge clock
//    reset : asynchronous, active-high reset
//    bus   : fetch_stage_if.slave (requests and imem word in, PC / IF/ID / fault / count out)
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 32
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.slave  bus
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // Low address bits are forced to zero so PC_out is always word aligned,
   // even for a misaligned RESET_PC parameter.
   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_if_pc;
   logic [31:0]      r_if_instr;
   logic             r_if_valid;
   logic             r_fault;
   logic [CNT_W-1:0] r_cnt;

   logic             w_misaligned;

   assign w_misaligned = (bus.branch_target[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC_AL;
         r_if_pc    <= 32'h0;
         r_if_instr <= NOP_INSTR;
         r_if_valid <= 1'b0;
         r_fault    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (bus.branch_taken) begin
                  // Any redirect flushes IF/ID; only an aligned one moves the PC.
                  r_if_valid <= 1'b0;
                  r_if_instr <= NOP_INSTR;
                  r_if_pc    <= 32'h0;
                  if (w_misaligned) begin
                     r_fault <= 1'b1;
                     r_state <= ST_HALT;
                  end else begin
                     r_pc <= {bus.branch_target[31:2], 2'b00};
                  end
               end else if (!bus.stall) begin
                  r_if_instr <= bus.instruction;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_pc       <= r_pc + 32'd4;   // wraps naturally at 2^32
                  if (r_cnt != CNT_MAX) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            ST_HALT: begin
               // Frozen until reset; IF/ID already holds the flushed NOP.
               r_if_valid <= 1'b0;
               r_if_instr <= NOP_INSTR;
               r_fault    <= 1'b1;
            end
            default: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   assign bus.PC_out      = r_pc;
   assign bus.if_id_pc    = r_if_pc;
   assign bus.if_id_instr = r_if_instr;
   assign bus.if_id_valid = r_if_valid;
   assign bus.fetch_fault = r_fault;
   assign bus.fetch_count = r_cnt;

endmodule
